processinho_core: RTL and testbench

Parametrised successor of the two-register processinho datapath. It holds a NUM_REGS x WIDTH register file and a sequenced ULA operating on any two registers, with write-back to any register. A multi-cycle double-dabble converter drives DIGITS active-low seven-segment displays.
- start/busy/done handshake replaces free-running combinational display decode.
- Sits between the board switches/keys and the HEX displays.

---
 rtl/processinho_pkg.sv | 46 ++++
 rtl/processinho_if.sv | 32 +++
 rtl/seg7_encoder.sv | 18 +
 rtl/processinho_core.sv | 185 ++++++++++++++++++
 tb/tb_processinho_core.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/processinho_pkg.sv
// Shared types and constants for the processinho datapath: opcodes, FSM states,
// seven-segment table and width helpers.
package processinho_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL1 = 4'd6,
        OP_SHR1 = 4'd7,
        OP_PASS = 4'd8,
        OP_INC  = 4'd9,
        OP_DEC  = 4'd10
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int OP_W          = 4;
    localparam int DEF_NUM_REGS  = 4;
    localparam int DEF_REG_SEL_W = $clog2(DEF_NUM_REGS);

    // Active-low segments, bit0=a .. bit6=g, bit7=dp (off)
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_TABLE [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/processinho_if.sv
// Operand/command and result/display bundle of processinho_core.
interface processinho_if #(
    parameter int WIDTH     = 8,
    parameter int REG_SEL_W = 2,
    parameter int DIGITS    = 3
);
    logic                   load_en;
    logic [REG_SEL_W-1:0]   load_sel;
    logic [WIDTH-1:0]       operando;
    logic                   start;
    logic [3:0]             ula_operation;
    logic [REG_SEL_W-1:0]   sel_a;
    logic [REG_SEL_W-1:0]   sel_b;
    logic [REG_SEL_W-1:0]   sel_dst;
    logic                   busy;
    logic                   done;
    logic [WIDTH:0]         result;
    logic                   neg;
    logic                   err;
    logic [8*DIGITS-1:0]    hex;

    modport master (
        output load_en, load_sel, operando, start, ula_operation, sel_a, sel_b, sel_dst,
        input  busy, done, result, neg, err, hex
    );

    modport slave (
        input  load_en, load_sel, operando, start, ula_operation, sel_a, sel_b, sel_dst,
        output busy, done, result, neg, err, hex
    );

endinterface

// File: rtl/seg7_encoder.sv
// One BCD digit to active-low seven-segment pattern; blank or non-decimal input
// turns every segment off.
module seg7_encoder
    import processinho_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (bcd < 4'd10)) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/processinho_core.sv
// Register file + sequenced ULA with double-dabble display conversion.
// Optional: PROCESSINHO_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module processinho_core
    import processinho_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4,
    parameter int DIGITS   = 3
) (
    input logic          clock,
    input logic          reset,
    processinho_if.slave bus
);

    localparam int REG_SEL_W = $clog2(NUM_REGS);
    localparam int CNT_W     = $clog2(WIDTH + 1);
    localparam int BCD_W     = 4 * DIGITS;
    localparam longint unsigned BIN_MAX = (longint'(1) << (WIDTH + 1)) - 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("processinho_core: WIDTH must be >= 2");
    end
    if ((NUM_REGS < 2) || ((1 << REG_SEL_W) != NUM_REGS)) begin : g_bad_regs
        $error("processinho_core: NUM_REGS must be a power of two >= 2");
    end
    if (pow10(DIGITS) <= BIN_MAX) begin : g_bad_digits
        $error("processinho_core: DIGITS too small for WIDTH+1 bit magnitude");
    end

    state_t                 state;
    logic [WIDTH-1:0]       rf [NUM_REGS];
    logic [3:0]             op_q;
    logic [REG_SEL_W-1:0]   a_q;
    logic [REG_SEL_W-1:0]   b_q;
    logic [REG_SEL_W-1:0]   dst_q;
    logic [WIDTH:0]         result_q;
    logic                   neg_q;
    logic                   err_q;
    logic [WIDTH:0]         sh;
    logic [BCD_W-1:0]       bcd;
    logic [CNT_W-1:0]       cnt;
    logic [BCD_W-1:0]       disp_q;

    logic [WIDTH-1:0]       opa;
    logic [WIDTH-1:0]       opb;
    logic [WIDTH:0]         r_full;
    logic [WIDTH-1:0]       rf_wdata;
    logic                   wr_en;
    logic                   neg_n;
    logic                   err_n;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       bcd_next;
    logic [DIGITS-1:0]      blank;
    logic [8*DIGITS-1:0]    hex_w;

    assign opa = rf[a_q];
    assign opb = rf[b_q];

    // SUB writes the wrapped difference but displays the magnitude
    always_comb begin
        r_full = '0;
        wr_en  = 1'b1;
        neg_n  = 1'b0;
        err_n  = 1'b0;
        case (op_q)
            OP_ADD:  r_full = {1'b0, opa} + {1'b0, opb};
            OP_SUB: begin
                neg_n  = (opa < opb);
                r_full = {1'b0, neg_n ? (opb - opa) : (opa - opb)};
            end
            OP_AND:  r_full = {1'b0, opa & opb};
            OP_OR:   r_full = {1'b0, opa | opb};
            OP_XOR:  r_full = {1'b0, opa ^ opb};
            OP_NOT:  r_full = {1'b0, ~opa};
            OP_SHL1: r_full = {opa, 1'b0};
            OP_SHR1: r_full = {2'b00, opa[WIDTH-1:1]};
            OP_PASS: r_full = {1'b0, opa};
            OP_INC:  r_full = {1'b0, opa} + (WIDTH + 1)'(1);
            OP_DEC:  r_full = {1'b0, opa - WIDTH'(1)};
            default: begin
                wr_en = 1'b0;
                err_n = 1'b1;
            end
        endcase
        rf_wdata = (op_q == OP_SUB) ? (opa - opb) : r_full[WIDTH-1:0];
    end

    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? (bcd[4*i +: 4] + 4'd3)
                                                         : bcd[4*i +: 4];
        end
        bcd_next = {bcd_adj[BCD_W-2:0], sh[WIDTH]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dst_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            sh       <= '0;
            bcd      <= '0;
            cnt      <= '0;
            disp_q   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.load_en) begin
                        rf[bus.load_sel] <= bus.operando;
                    end
                    if (bus.start) begin
                        op_q  <= bus.ula_operation;
                        a_q   <= bus.sel_a;
                        b_q   <= bus.sel_b;
                        dst_q <= bus.sel_dst;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (wr_en) begin
                        rf[dst_q] <= rf_wdata;
                    end
                    result_q <= r_full;
                    neg_q    <= neg_n;
                    err_q    <= err_n;
                    sh       <= r_full;
                    bcd      <= '0;
                    cnt      <= '0;
                    state    <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    bcd <= bcd_next;
                    sh  <= {sh[WIDTH-1:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                    // Display registers take the final shift directly so hex never sees partial values
                    if (cnt == CNT_W'(WIDTH)) begin
                        disp_q <= bcd_next;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PROCESSINHO_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic lead;
        lead  = 1'b1;
        blank = '0;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            lead               = lead & (disp_q[4*(DIGITS-k) +: 4] == 4'd0);
            blank[DIGITS-k]    = lead;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_encoder u_seg (
            .bcd   (disp_q[4*g +: 4]),
            .blank (blank[g]),
            .seg   (hex_w[8*g +: 8])
        );
    end

    assign bus.busy   = (state != ST_IDLE);
    assign bus.done   = (state == ST_DONE);
    assign bus.result = result_q;
    assign bus.neg    = neg_q;
    assign bus.err    = err_q;
    assign bus.hex    = hex_w;

endmodule

// File: tb/tb_processinho_core.sv
// Scoreboard bench for processinho_core: stimulus queues expected results, a
// monitor checks them on every done pulse.
`timescale 1ns/1ps
module tb_processinho_core;
    import processinho_pkg::*;

    localparam int WIDTH     = 8;
    localparam int NUM_REGS  = 4;
    localparam int REG_SEL_W = 2;
    localparam int DIGITS    = 3;
`ifdef PROCESSINHO_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    processinho_if #(.WIDTH(WIDTH), .REG_SEL_W(REG_SEL_W), .DIGITS(DIGITS)) bus();

    processinho_core #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .DIGITS(DIGITS)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [WIDTH:0]      res;
        logic                neg;
        logic                err;
        logic [8*DIGITS-1:0] hex;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   issued = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input int unsigned d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    function automatic logic [8*DIGITS-1:0] exp_hex(input int unsigned v);
        logic [8*DIGITS-1:0] h;
        int unsigned d [DIGITS];
        int unsigned x;
        bit lead;
        x = v;
        lead = 1'b1;
        h = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d[i] = x % 10;
            x = x / 10;
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (BLANK_EN && lead && (i > 0) && (d[i] == 0)) begin
                h[8*i +: 8] = 8'hFF;
            end else begin
                lead = 1'b0;
                h[8*i +: 8] = seg_of(d[i]);
            end
        end
        return h;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("result", 32'(bus.result), 32'(mon_e.res));
                chk("neg", 32'(bus.neg), 32'(mon_e.neg));
                chk("err", 32'(bus.err), 32'(mon_e.err));
                chk("hex", 32'(bus.hex), 32'(mon_e.hex));
            end
        end
    end

    task automatic do_op(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] dst, input logic [WIDTH:0] er, input bit en,
                         input bit ee, input bit poke, input bit ld,
                         input logic [1:0] ld_sel, input logic [7:0] ld_val);
        exp_t e;
        int lat;
        e.res = er;
        e.neg = en;
        e.err = ee;
        e.hex = exp_hex(32'(er));
        sb.push_back(e);
        issued++;
        @(negedge clk);
        bus.start = 1'b1;
        bus.ula_operation = op;
        bus.sel_a = a;
        bus.sel_b = b;
        bus.sel_dst = dst;
        if (ld) begin
            bus.load_en = 1'b1;
            bus.load_sel = ld_sel;
            bus.operando = ld_val;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.load_en = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (poke && k == 3) begin
                bus.start = 1'b1;
                bus.load_en = 1'b1;
                bus.load_sel = 2'd0;
                bus.operando = 8'd7;
            end
            if (poke && k == 5) begin
                bus.start = 1'b0;
                bus.load_en = 1'b0;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(WIDTH + 2));
        @(posedge clk);
        #1;
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic run(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] dst, input logic [WIDTH:0] er, input bit en, input bit ee);
        do_op(op, a, b, dst, er, en, ee, 1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic do_load(input logic [1:0] sel, input logic [7:0] v);
        @(negedge clk);
        bus.load_en = 1'b1;
        bus.load_sel = sel;
        bus.operando = v;
        @(posedge clk);
        #1;
        bus.load_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        bus.load_en = 1'b0;
        bus.load_sel = '0;
        bus.operando = '0;
        bus.start = 1'b0;
        bus.ula_operation = '0;
        bus.sel_a = '0;
        bus.sel_b = '0;
        bus.sel_dst = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hex", 32'(bus.hex), 32'(exp_hex(0)));
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_neg", 32'(bus.neg), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        for (int i = 0; i < NUM_REGS; i++) begin
            run(OP_PASS, 2'(i), 2'd0, 2'(i), 9'd0, 1'b0, 1'b0);
        end

        // carry into display, wrapped register value
        do_load(2'd0, 8'd200);
        do_load(2'd1, 8'd100);
        run(OP_ADD, 2'd0, 2'd1, 2'd2, 9'd300, 1'b0, 1'b0);
        run(OP_PASS, 2'd2, 2'd0, 2'd2, 9'd44, 1'b0, 1'b0);

        // negative subtraction
        do_load(2'd0, 8'd5);
        do_load(2'd1, 8'd9);
        run(OP_SUB, 2'd0, 2'd1, 2'd3, 9'd4, 1'b1, 1'b0);
        run(OP_PASS, 2'd3, 2'd0, 2'd3, 9'd252, 1'b0, 1'b0);

        // start/load during conversion ignored
        dc = done_cnt;
        do_op(OP_ADD, 2'd0, 2'd1, 2'd2, 9'd14, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("single_done", 32'(done_cnt - dc), 32'd1);
        run(OP_PASS, 2'd0, 2'd0, 2'd0, 9'd5, 1'b0, 1'b0);

        // reserved opcode, then err cleared
        run(4'd13, 2'd0, 2'd1, 2'd2, 9'd0, 1'b0, 1'b1);
        run(OP_PASS, 2'd2, 2'd0, 2'd2, 9'd14, 1'b0, 1'b0);

        // load and start together: ULA sees new r1
        do_op(OP_ADD, 2'd0, 2'd1, 2'd1, 9'd55, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'd50);

        do_load(2'd0, 8'd200);
        run(OP_SHL1, 2'd0, 2'd0, 2'd3, 9'd400, 1'b0, 1'b0);
        run(OP_PASS, 2'd3, 2'd0, 2'd3, 9'd144, 1'b0, 1'b0);
        run(OP_SHR1, 2'd0, 2'd0, 2'd2, 9'd100, 1'b0, 1'b0);
        run(OP_AND, 2'd0, 2'd1, 2'd2, 9'd0, 1'b0, 1'b0);
        run(OP_OR, 2'd0, 2'd1, 2'd2, 9'd255, 1'b0, 1'b0);
        run(OP_XOR, 2'd0, 2'd1, 2'd2, 9'd255, 1'b0, 1'b0);
        run(OP_NOT, 2'd0, 2'd0, 2'd2, 9'd55, 1'b0, 1'b0);
        do_load(2'd0, 8'd255);
        run(OP_INC, 2'd0, 2'd0, 2'd2, 9'd256, 1'b0, 1'b0);
        run(OP_PASS, 2'd2, 2'd0, 2'd2, 9'd0, 1'b0, 1'b0);
        run(OP_DEC, 2'd2, 2'd0, 2'd3, 9'd255, 1'b0, 1'b0);
        run(OP_SUB, 2'd0, 2'd3, 2'd1, 9'd0, 1'b0, 1'b0);

        // reset in the middle of conversion
        @(negedge clk);
        bus.start = 1'b1;
        bus.ula_operation = OP_SUB;
        bus.sel_a = 2'd0;
        bus.sel_b = 2'd1;
        bus.sel_dst = 2'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_hex", 32'(bus.hex), 32'(exp_hex(0)));
        chk("midrst_result", 32'(bus.result), 32'd0);
        dc = done_cnt;
        repeat (15) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt - dc), 32'd0);
        run(OP_PASS, 2'd0, 2'd0, 2'd0, 9'd0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(issued));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
